// File: rtl/sig_pulse_stretch_mc.sv
// sig_pulse_stretch_mc
// Multi-channel registered signal path: each channel runs through a DELAY-stage
// pipeline and then either passes straight through or drives an edge-triggered
// pulse stretcher that guarantees STRETCH-cycle-wide output pulses.
module sig_pulse_stretch_mc #(
  parameter int CH      = 4,
  parameter int DELAY   = 2,
  parameter int STRETCH = 4,
  parameter bit RETRIG  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic          clr_miss,
  input  logic [CH-1:0] in_signal,
  output logic [CH-1:0] out_signal,
  output logic [CH-1:0] busy,
  output logic [CH-1:0] miss
);

  localparam int CW = $clog2(STRETCH + 1);
  localparam logic [CW-1:0] LOAD = CW'(STRETCH);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_ANY  = 2'b11;

  logic [CH-1:0]         pipe [DELAY];
  logic [CH-1:0]         d;
  logic [CH-1:0]         prev;
  logic [DELAY:0]        primed;
  logic [CH-1:0]         rise;
  logic [CH-1:0]         fall;
  logic [CH-1:0]         edge_hit;
  logic [CH-1:0]         stretch_on;
  logic [CH-1:0]         miss_set;
  logic [CH-1:0][CW-1:0] cnt;
  logic [CH-1:0][CW-1:0] cnt_nxt;

  assign d = pipe[DELAY-1];

  // Input pipeline plus the previous-sample stage; shifts every cycle and
  // tracks which stages hold real post-reset samples so reset release alone
  // never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DELAY; k++) begin
        pipe[k] <= '0;
      end
      prev   <= '0;
      primed <= '0;
    end else begin
      pipe[0] <= in_signal;
      for (int k = 1; k < DELAY; k++) begin
        pipe[k] <= pipe[k-1];
      end
      prev   <= d;
      primed <= {primed[DELAY-1:0], 1'b1};
    end
  end

  // Edge selection and next counter value per channel.
  always_comb begin
    rise       = d & ~prev & {CH{primed[DELAY]}};
    fall       = ~d & prev & {CH{primed[DELAY]}};
    edge_hit   = '0;
    cnt_nxt    = cnt;
    miss_set   = '0;
    stretch_on = '0;
    case (mode)
      MODE_RISE: edge_hit = rise;
      MODE_FALL: edge_hit = fall;
      MODE_ANY:  edge_hit = rise | fall;
      default:   edge_hit = '0;
    endcase
    for (int c = 0; c < CH; c++) begin
      if (mode == MODE_PASS || !en) begin
        cnt_nxt[c] = '0;
      end else if (edge_hit[c] && (cnt[c] == '0 || RETRIG)) begin
        cnt_nxt[c] = LOAD;
      end else if (edge_hit[c]) begin
        cnt_nxt[c]  = cnt[c] - CW'(1);
        miss_set[c] = 1'b1;
      end else if (cnt[c] != '0) begin
        cnt_nxt[c] = cnt[c] - CW'(1);
      end
      stretch_on[c] = (cnt_nxt[c] != '0);
    end
  end

  // Counter, output, busy and sticky miss registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      out_signal <= '0;
      busy       <= '0;
      miss       <= '0;
    end else begin
      cnt        <= cnt_nxt;
      busy       <= stretch_on;
      out_signal <= (mode == MODE_PASS) ? d : stretch_on;
      miss       <= (clr_miss ? '0 : miss) | miss_set;
    end
  end

endmodule

// File: doc/sig_pulse_stretch_mc.md
Name: sig_pulse_stretch_mc

Overview:
- Parametrised multi-channel successor to the single-bit registered signal path (`m_simple`).
- Each of CH input channels passes through a DELAY-stage register pipeline, then goes to a per-channel output stage.
- The output stage is either a delayed pass-through or an edge-triggered pulse stretcher (rise, fall or any edge) with optional retrigger and a sticky missed-edge flag.
- Sits between raw control/status inputs and downstream logic that needs cleanly timed, minimum-width pulses.

Parameters:
- CH, 4, number of independent channels (>=1).
- DELAY, 2, pipeline stages between input and detector (>=1).
- STRETCH, 4, output pulse width in clock cycles (>=1).
- RETRIG, 1, 1 = an edge while busy reloads the counter; 0 = the edge is ignored and flagged as missed.
- CW, $clog2(STRETCH+1), counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  stretcher enable; 0 clears counters and forces stretch outputs low.
- mode  input  2  00 delayed pass-through, 01 rise-stretch, 10 fall-stretch, 11 any-edge-stretch.
- clr_miss  input  1  synchronous clear of all miss flags.
- in_signal  input  CH  per-channel input.
- out_signal  output  CH  per-channel output.
- busy  output  CH  per-channel counter nonzero.
- miss  output  CH  sticky: edge dropped while busy (RETRIG=0 only).

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-pulse):
  - All pipeline stages, the prev stage, counters, out_signal, busy and miss go to 0.
  - Counters restart from 0 after release; no edge is generated by reset release itself.
- Pipeline:
  - s[0] <= in_signal; s[k] <= s[k-1]; d = s[DELAY-1]; prev <= d.
  - The pipeline always shifts, regardless of en and mode.
- Edge detection (per channel, combinational on registered d and prev):
  - rise = d & ~prev; fall = ~d & prev.
  - edge selected by mode: 01 = rise, 10 = fall, 11 = rise | fall, 00 = none.
- Mode 00:
  - out_signal <= d (registered); busy = 0; counters held at 0.
  - Latency: an input first sampled high at edge E0 appears on out_signal after edge E0+DELAY.
- Stretch modes (01/10/11), per-channel counter cnt[CW-1:0]:
  - en=0: cnt <= 0.
  - else if edge && (cnt==0 || RETRIG): cnt <= STRETCH.
  - else if edge && cnt!=0 && !RETRIG: cnt <= cnt-1 and miss <= 1.
  - else if cnt!=0: cnt <= cnt-1.
  - out_signal and busy are both registered equal to (next cnt != 0), so out is high exactly STRETCH cycles per accepted edge.
  - Latency is identical to mode 00: an edge sampled at E0 gives out high after E0+DELAY, through E0+DELAY+STRETCH-1.
  - Input pulses shorter than STRETCH are widened; longer inputs still produce exactly STRETCH cycles (stretcher, not follower).
  - Any-edge mode with a 1-cycle input pulse yields a rise then a fall one cycle apart. With RETRIG=1 the fall reloads, giving STRETCH+1 cycles high. With RETRIG=0 the fall sets miss.
- miss:
  - Sticky per channel; cleared only by clr_miss or reset.
  - clr_miss and a new miss event in the same cycle: set wins.
  - Never set when RETRIG=1 or in mode 00.
- Mode change:
  - Takes effect at the next edge.
  - Switching to 00 zeroes counters and out follows d at the same edge.
  - Switching between stretch modes lets active counters run down.
- Channels are fully independent; there is no cross-channel interaction.
- Counter arithmetic: no wrap; decrement only when nonzero; STRETCH must fit in CW bits.

Test Plan:
- Defaults; mode=00, in_signal=4'b0001 sampled at E0 -> out_signal=4'b0001 after E0+2, and 0 two cycles after the input drops.
- mode=01, ch0 one-cycle high pulse at E0 -> out_signal[0] high for exactly 4 cycles (E0+2 .. E0+5), busy[0] matches, miss=0.
- mode=01, RETRIG=1, second rise on ch1 3 cycles after the first -> out_signal[1] high 7 consecutive cycles; with RETRIG=0 -> 4 cycles high and miss[1]=1 until clr_miss; clr_miss together with a new miss keeps miss=1.
- mode=11, ch2 input high for 6 cycles -> two 4-cycle output pulses, separated by 2 low cycles.
- rst_n driven low mid-pulse (cnt=2) -> out_signal, busy and miss go to 0 immediately without a clock; input steady high across reset release -> no output pulse.
- en=0 during a pending edge -> no pulse; en back to 1 -> next fresh edge gives a normal 4-cycle pulse.
